// File: rtl/tlb_miss_arbiter.sv
// tlb_miss_arbiter: shares the single L2 TLB search port between the
// inst-side (port 0) and data-side (port 1) tcache miss handlers.
// One miss is in flight at a time: accept -> lookup -> response.
// A TLB write or invtlb seen during the lookup or the response cycle
// turns the response into a retry, so a stale translation is never refilled.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no miss in flight; arbitrate and accept one requester
// S_LOOKUP | l2_valid issued with the latched vppn/asid
// S_RESP   | L2 result returned to the owner, refill strobed on a clean hit
module tlb_miss_arbiter #(
   parameter int TLBIDLEN = 4,
   parameter int VPPN_W   = 19,
   parameter int ASID_W   = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req0_valid,
   input  logic [VPPN_W-1:0]   req0_vppn,
   input  logic [ASID_W-1:0]   req0_asid,
   output logic                req0_ready,
   output logic                resp0_valid,
   output logic                resp0_found,
   output logic                resp0_retry,
   output logic [TLBIDLEN-1:0] resp0_index,
   output logic                refill0_valid,
   input  logic                req1_valid,
   input  logic [VPPN_W-1:0]   req1_vppn,
   input  logic [ASID_W-1:0]   req1_asid,
   output logic                req1_ready,
   output logic                resp1_valid,
   output logic                resp1_found,
   output logic                resp1_retry,
   output logic [TLBIDLEN-1:0] resp1_index,
   output logic                refill1_valid,
   output logic                l2_valid,
   output logic [VPPN_W-1:0]   l2_vppn,
   output logic [ASID_W-1:0]   l2_asid,
   input  logic                l2_found,
   input  logic [TLBIDLEN-1:0] l2_index,
   input  logic                flush,
   output logic                busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_rr_ptr;
   logic                r_owner;
   logic                r_abort;
   logic [VPPN_W-1:0]   r_vppn;
   logic [ASID_W-1:0]   r_asid;

   logic                w_grant;
   logic                w_winner;
   logic                w_retry;
   logic                w_found;
   logic [TLBIDLEN-1:0] w_index;

   // round-robin pick: the pointer only matters when both sides are asking
   assign w_winner = (req0_valid & req1_valid) ? r_rr_ptr : req1_valid;

   assign l2_vppn = r_vppn;
   assign l2_asid = r_asid;
   assign busy    = (r_state != S_IDLE);

   // next state and all strobes; everything is held low while reset is high
   always_comb begin
      w_next        = r_state;
      w_grant       = 1'b0;
      w_retry       = 1'b0;
      w_found       = 1'b0;
      w_index       = '0;
      req0_ready    = 1'b0;
      req1_ready    = 1'b0;
      l2_valid      = 1'b0;
      resp0_valid   = 1'b0;
      resp0_found   = 1'b0;
      resp0_retry   = 1'b0;
      resp0_index   = '0;
      refill0_valid = 1'b0;
      resp1_valid   = 1'b0;
      resp1_found   = 1'b0;
      resp1_retry   = 1'b0;
      resp1_index   = '0;
      refill1_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!reset && !flush && (req0_valid | req1_valid)) begin
               w_grant    = 1'b1;
               req0_ready = ~w_winner;
               req1_ready = w_winner;
               w_next     = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            l2_valid = ~reset;
            w_next   = S_RESP;
         end
         S_RESP: begin
            w_retry = r_abort | flush;
            w_found = ~w_retry & l2_found;
            w_index = w_found ? l2_index : '0;
            if (!reset) begin
               if (r_owner) begin
                  resp1_valid   = 1'b1;
                  resp1_found   = w_found;
                  resp1_retry   = w_retry;
                  resp1_index   = w_index;
                  refill1_valid = w_found;
               end else begin
                  resp0_valid   = 1'b1;
                  resp0_found   = w_found;
                  resp0_retry   = w_retry;
                  resp0_index   = w_index;
                  refill0_valid = w_found;
               end
            end
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // state, arbitration pointer, latched request and flush-abort flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= 1'b0;
         r_owner  <= 1'b0;
         r_abort  <= 1'b0;
         r_vppn   <= '0;
         r_asid   <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_owner  <= w_winner;
            r_rr_ptr <= ~w_winner;
            r_vppn   <= w_winner ? req1_vppn : req0_vppn;
            r_asid   <= w_winner ? req1_asid : req0_asid;
         end
         if (r_state == S_LOOKUP)
            r_abort <= flush;
         else if (r_state == S_RESP)
            r_abort <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tlb_miss_arbiter.sv
// Bench for tlb_miss_arbiter: directed scenarios followed by a randomized
// run against a transaction-level model (accept time + fixed latency).
module tb_tlb_miss_arbiter;

   localparam int TLBIDLEN = 4;
   localparam int VPPN_W   = 19;
   localparam int ASID_W   = 10;

   logic                clk;
   logic                reset;
   logic                req0_valid, req1_valid;
   logic [VPPN_W-1:0]   req0_vppn, req1_vppn;
   logic [ASID_W-1:0]   req0_asid, req1_asid;
   logic                req0_ready, req1_ready;
   logic                resp0_valid, resp0_found, resp0_retry, refill0_valid;
   logic                resp1_valid, resp1_found, resp1_retry, refill1_valid;
   logic [TLBIDLEN-1:0] resp0_index, resp1_index;
   logic                l2_valid;
   logic [VPPN_W-1:0]   l2_vppn;
   logic [ASID_W-1:0]   l2_asid;
   logic                l2_found;
   logic [TLBIDLEN-1:0] l2_index;
   logic                flush;
   logic                busy;

   int n_pass  = 0;
   int n_total = 0;

   tlb_miss_arbiter #(.TLBIDLEN(TLBIDLEN), .VPPN_W(VPPN_W), .ASID_W(ASID_W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_vppn(req0_vppn), .req0_asid(req0_asid),
      .req0_ready(req0_ready), .resp0_valid(resp0_valid), .resp0_found(resp0_found),
      .resp0_retry(resp0_retry), .resp0_index(resp0_index), .refill0_valid(refill0_valid),
      .req1_valid(req1_valid), .req1_vppn(req1_vppn), .req1_asid(req1_asid),
      .req1_ready(req1_ready), .resp1_valid(resp1_valid), .resp1_found(resp1_found),
      .resp1_retry(resp1_retry), .resp1_index(resp1_index), .refill1_valid(refill1_valid),
      .l2_valid(l2_valid), .l2_vppn(l2_vppn), .l2_asid(l2_asid),
      .l2_found(l2_found), .l2_index(l2_index), .flush(flush), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // advance to just after the next rising edge; inputs are then changed
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req0_valid = 0; req0_vppn = '0; req0_asid = '0;
      req1_valid = 0; req1_vppn = '0; req1_asid = '0;
      l2_found = 0; l2_index = '0; flush = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      clear_inputs();
      cyc(); cyc();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      clear_inputs();
      req0_valid = 1; req1_valid = 1;
      cyc(); cyc();
      #1;
      n_total++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid, refill0_valid,
           refill1_valid, l2_valid, busy} !== 8'h00)
         $display("FAIL reset_outputs got %b expected 00000000",
                  {req0_ready, req1_ready, resp0_valid, resp1_valid, refill0_valid,
                   refill1_valid, l2_valid, busy});
      else n_pass++;
      clear_inputs();
      cyc();
      reset = 0;
   endtask

   task automatic test_single_hit();
      do_reset();
      req0_valid = 1; req0_vppn = 19'h12345; req0_asid = 10'h2a;
      #1;
      n_total++;
      if ({req0_ready, req1_ready} !== 2'b10)
         $display("FAIL hit_ready got %b expected 10", {req0_ready, req1_ready});
      else n_pass++;
      cyc();
      req0_valid = 0;
      #1;
      n_total++;
      if ({l2_valid, l2_vppn, l2_asid, busy} !== {1'b1, 19'h12345, 10'h2a, 1'b1})
         $display("FAIL hit_lookup got v=%b vppn=%h asid=%h busy=%b expected 1 12345 02a 1",
                  l2_valid, l2_vppn, l2_asid, busy);
      else n_pass++;
      cyc();
      l2_found = 1; l2_index = 4'd5;
      #1;
      n_total++;
      if ({resp0_valid, resp0_found, resp0_retry, resp0_index, refill0_valid,
           resp1_valid, refill1_valid} !== {3'b110, 4'd5, 3'b100})
         $display("FAIL hit_resp got v=%b f=%b r=%b idx=%0d refill=%b other=%b%b expected 1 1 0 5 1 00",
                  resp0_valid, resp0_found, resp0_retry, resp0_index, refill0_valid,
                  resp1_valid, refill1_valid);
      else n_pass++;
      cyc();
      l2_found = 0;
      #1;
      n_total++;
      if ({resp0_valid, busy} !== 2'b00)
         $display("FAIL hit_done got resp=%b busy=%b expected 0 0", resp0_valid, busy);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int granted;
      do_reset();
      req0_valid = 1; req0_vppn = 19'h00aaa;
      req1_valid = 1; req1_vppn = 19'h00bbb;
      for (int k = 0; k < 4; k++) begin
         granted = 0;
         for (int w = 0; w < 6 && granted == 0; w++) begin
            #1;
            if (req0_ready | req1_ready) begin
               granted = 1;
               n_total++;
               if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
                  $display("FAIL alternate_grant%0d got %b expected %b", k,
                           {req0_ready, req1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
               else n_pass++;
            end
            cyc();
         end
         if (granted == 0) begin
            n_total++;
            $display("FAIL alternate_timeout%0d got no grant expected grant within 6 cycles", k);
         end
      end
      clear_inputs();
      cyc(); cyc(); cyc();
   endtask

   task automatic test_miss();
      do_reset();
      req1_valid = 1; req1_vppn = 19'h7_0001; req1_asid = 10'h3;
      #1;
      n_total++;
      if ({req0_ready, req1_ready} !== 2'b01)
         $display("FAIL miss_ready got %b expected 01", {req0_ready, req1_ready});
      else n_pass++;
      cyc();
      req1_valid = 0;
      cyc();
      l2_found = 0; l2_index = 4'd7;
      #1;
      n_total++;
      if ({resp1_valid, resp1_found, resp1_retry, resp1_index, refill1_valid,
           resp0_valid, refill0_valid} !== {3'b100, 4'd0, 3'b000})
         $display("FAIL miss_resp got v=%b f=%b r=%b idx=%0d refill=%b other=%b%b expected 1 0 0 0 0 00",
                  resp1_valid, resp1_found, resp1_retry, resp1_index, refill1_valid,
                  resp0_valid, refill0_valid);
      else n_pass++;
      cyc();
   endtask

   task automatic test_flush_lookup();
      do_reset();
      req1_valid = 1; req1_vppn = 19'h5_4321; req1_asid = 10'h11;
      cyc();
      req1_valid = 0; flush = 1;
      cyc();
      flush = 0; l2_found = 1; l2_index = 4'd9;
      #1;
      n_total++;
      if ({resp1_valid, resp1_found, resp1_retry, resp1_index, refill1_valid} !== {3'b101, 4'd0, 1'b0})
         $display("FAIL flush_retry got v=%b f=%b r=%b idx=%0d refill=%b expected 1 0 1 0 0",
                  resp1_valid, resp1_found, resp1_retry, resp1_index, refill1_valid);
      else n_pass++;
      cyc();
      req1_valid = 1;
      #1;
      n_total++;
      if (req1_ready !== 1'b1)
         $display("FAIL flush_rerequest got ready=%b expected 1", req1_ready);
      else n_pass++;
      cyc();
      req1_valid = 0;
      cyc();
      #1;
      n_total++;
      if ({resp1_valid, resp1_found, resp1_retry, resp1_index, refill1_valid} !== {3'b110, 4'd9, 1'b1})
         $display("FAIL flush_rehit got v=%b f=%b r=%b idx=%0d refill=%b expected 1 1 0 9 1",
                  resp1_valid, resp1_found, resp1_retry, resp1_index, refill1_valid);
      else n_pass++;
      cyc();
      clear_inputs();
   endtask

   task automatic test_flush_idle();
      do_reset();
      req0_valid = 1; req1_valid = 1; flush = 1;
      #1;
      n_total++;
      if ({req0_ready, req1_ready, busy} !== 3'b000)
         $display("FAIL flush_idle_block got %b expected 000", {req0_ready, req1_ready, busy});
      else n_pass++;
      cyc();
      flush = 0;
      #1;
      n_total++;
      if ({req0_ready, req1_ready} !== 2'b10)
         $display("FAIL flush_idle_grant got %b expected 10", {req0_ready, req1_ready});
      else n_pass++;
      cyc();
      clear_inputs();
      cyc(); cyc();
   endtask

   task automatic test_reset_in_resp();
      do_reset();
      req0_valid = 1; req0_vppn = 19'h0_0f0f;
      cyc();
      req0_valid = 0;
      cyc();
      reset = 1; l2_found = 1; l2_index = 4'd3;
      #1;
      n_total++;
      if ({resp0_valid, refill0_valid, resp1_valid, refill1_valid} !== 4'b0000)
         $display("FAIL rst_resp_pulse got %b expected 0000",
                  {resp0_valid, refill0_valid, resp1_valid, refill1_valid});
      else n_pass++;
      cyc();
      reset = 0; l2_found = 0;
      #1;
      n_total++;
      if (busy !== 1'b0)
         $display("FAIL rst_busy got %b expected 0", busy);
      else n_pass++;
      req0_valid = 1; req1_valid = 1;
      #1;
      n_total++;
      if ({req0_ready, req1_ready} !== 2'b10)
         $display("FAIL rst_rr_ptr got %b expected 10", {req0_ready, req1_ready});
      else n_pass++;
      clear_inputs();
      cyc(); cyc(); cyc();
   endtask

   // randomized traffic; the model tracks one transaction by its accept cycle
   task automatic test_random();
      int          n;
      bit          active, aborted, rr, owner, in_flight, gw;
      int          acc;
      logic [VPPN_W-1:0] mv;
      logic [ASID_W-1:0] ma;
      logic [48:0] exp_v, act_v;
      logic        e_rdy0, e_rdy1, e_l2v, e_busy;
      logic        e_rv0, e_f0, e_r0, e_rf0, e_rv1, e_f1, e_r1, e_rf1;
      logic [TLBIDLEN-1:0] e_i0, e_i1;
      logic [VPPN_W-1:0]   e_vppn;
      logic [ASID_W-1:0]   e_asid;
      logic        rtry, fnd;
      do_reset();
      active = 0; aborted = 0; rr = 0; owner = 0; acc = 0; mv = '0; ma = '0;
      for (n = 0; n < 600; n++) begin
         if (!req0_valid && $urandom_range(2) == 0) begin
            req0_valid = 1; req0_vppn = VPPN_W'($urandom); req0_asid = ASID_W'($urandom);
         end
         if (!req1_valid && $urandom_range(2) == 0) begin
            req1_valid = 1; req1_vppn = VPPN_W'($urandom); req1_asid = ASID_W'($urandom);
         end
         flush    = ($urandom_range(5) == 0);
         l2_found = ($urandom_range(1) == 1);
         l2_index = TLBIDLEN'($urandom);
         #1;
         {e_rdy0, e_rdy1, e_l2v} = '0;
         {e_rv0, e_f0, e_r0, e_rf0, e_rv1, e_f1, e_r1, e_rf1} = '0;
         e_i0 = '0; e_i1 = '0; e_vppn = '0; e_asid = '0;
         in_flight = active && (n == acc + 1 || n == acc + 2);
         e_busy = in_flight;
         if (active && n == acc + 1) begin
            e_l2v = 1; e_vppn = mv; e_asid = ma;
            aborted = flush;
         end
         if (active && n == acc + 2) begin
            rtry = aborted || flush;
            fnd  = !rtry && l2_found;
            if (owner) begin
               e_rv1 = 1; e_f1 = fnd; e_r1 = rtry; e_rf1 = fnd; e_i1 = fnd ? l2_index : '0;
            end else begin
               e_rv0 = 1; e_f0 = fnd; e_r0 = rtry; e_rf0 = fnd; e_i0 = fnd ? l2_index : '0;
            end
            active = 0;
         end
         gw = 0;
         if (!in_flight && !flush && (req0_valid || req1_valid)) begin
            gw = (req0_valid && req1_valid) ? rr : req1_valid;
            if (gw) e_rdy1 = 1; else e_rdy0 = 1;
            owner = gw; rr = !gw; acc = n; active = 1;
            mv = gw ? req1_vppn : req0_vppn;
            ma = gw ? req1_asid : req0_asid;
         end
         exp_v = {e_rdy0, e_rdy1, e_rv0, e_f0, e_r0, e_i0, e_rf0,
                  e_rv1, e_f1, e_r1, e_i1, e_rf1, e_l2v, e_vppn, e_asid, e_busy};
         act_v = {req0_ready, req1_ready, resp0_valid, resp0_found, resp0_retry, resp0_index,
                  refill0_valid, resp1_valid, resp1_found, resp1_retry, resp1_index,
                  refill1_valid, l2_valid, l2_vppn & {VPPN_W{l2_valid}},
                  l2_asid & {ASID_W{l2_valid}}, busy};
         n_total++;
         if (act_v !== exp_v)
            $display("FAIL random_cycle%0d got %h expected %h", n, act_v, exp_v);
         else n_pass++;
         cyc();
         if (e_rdy0) req0_valid = 0;
         if (e_rdy1) req1_valid = 0;
      end
      clear_inputs();
   endtask

   initial begin
      reset = 1;
      clear_inputs();
      test_reset();
      test_single_hit();
      test_back_to_back();
      test_miss();
      test_flush_lookup();
      test_flush_idle();
      test_reset_in_resp();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1);
   end

endmodule
